// File: rtl/note_seq_datapath.sv
// ----------------------------------------------------------------------------
// note_seq_datapath
//
// Records {octave, note} codes into a DEPTH-slot sequence and plays them back
// one slot per next_note pulse. Every recorded slot and every played slot
// produces one VGA cell-draw request, carried to the drawing block through a
// single-entry ready/valid holding register.
//
// Parameters:
//   DEPTH   number of sequence slots (power of two, 2..64)
//   ADDR_W  log2(DEPTH)
//   COLS    grid columns (power of two, divides DEPTH)
//   CELL_W  cell width in pixels
//   CELL_H  cell height in pixels
//   GAP     pixel gap around cells
//
// Ports:
//   clk, reset           clock; synchronous active-low reset
//   note_data[3:0]       note code to record
//   octave_data[1:0]     octave code to record
//   rec_strobe           append {octave_data, note_data}
//   play_start           start (or restart) playback at slot 0
//   next_note            advance playback by one slot
//   clear                empty the sequence and stop playback
//   note_out[5:0]        current playback code, 0 when not playing
//   note_valid           note_out is meaningful
//   play_active          FSM is in PLAY
//   play_done            one-cycle pulse when playback ends
//   count[ADDR_W:0]      number of recorded notes
//   full                 count == DEPTH
//   overflow             one-cycle pulse when a record is dropped (full)
//   busy                 draw request pending and not accepted this cycle
//   draw_valid           draw request pending
//   draw_ready           drawing block accepts the request
//   draw_x[7:0]          top-left x of the cell
//   draw_y[6:0]          top-left y of the cell
//   draw_colour[2:0]     3'b100 recorded cell, 3'b110 playback highlight
//
// Configuration macro:
//   NOTE_SEQ_LOOP_EN     when defined, playback wraps from the last slot back
//                        to slot 0 instead of ending.
// ----------------------------------------------------------------------------
module note_seq_datapath #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int COLS   = 4,
    parameter int CELL_W = 36,
    parameter int CELL_H = 12,
    parameter int GAP    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        note_data,
    input  logic [1:0]        octave_data,
    input  logic              rec_strobe,
    input  logic              play_start,
    input  logic              next_note,
    input  logic              clear,
    output logic [5:0]        note_out,
    output logic              note_valid,
    output logic              play_active,
    output logic              play_done,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              overflow,
    output logic              busy,
    output logic              draw_valid,
    input  logic              draw_ready,
    output logic [7:0]        draw_x,
    output logic [6:0]        draw_y,
    output logic [2:0]        draw_colour
);

`ifdef NOTE_SEQ_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    localparam int              COL_PITCH      = CELL_W + GAP;
    localparam int              ROW_PITCH      = CELL_H + GAP;
    localparam logic [ADDR_W:0] DEPTH_CNT      = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE        = (ADDR_W+1)'(1);
    localparam logic [2:0]      COLOUR_REC     = 3'b100;
    localparam logic [2:0]      COLOUR_HILITE  = 3'b110;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   ptr;
    logic [5:0]          mem [DEPTH];

    logic                do_rec;
    logic                do_ovf;
    logic                do_step;
    logic                do_wrap;
    logic                do_finish;
    logic                ptr_last;
    logic                leave_play;
    logic                load_en;
    logic [ADDR_W-1:0]   load_slot;
    logic [2:0]          load_colour;

    // Grid placement of a slot: column is the low part of the slot index,
    // row the high part; results are truncated to the VGA coordinate widths.
    function automatic logic [7:0] cell_x(input logic [ADDR_W-1:0] slot);
        int col;
        col = int'(slot) % COLS;
        return 8'(GAP + col * COL_PITCH);
    endfunction

    function automatic logic [6:0] cell_y(input logic [ADDR_W-1:0] slot);
        int row;
        row = int'(slot) / COLS;
        return 7'(GAP + row * ROW_PITCH);
    endfunction

    assign full        = (count == DEPTH_CNT);
    assign busy        = draw_valid && !draw_ready;
    assign play_active = (state == PLAY);

    // Command decode. The if/else chain encodes the pulse priority
    // clear > play_start > rec_strobe > next_note. A record while the
    // holding register is busy is dropped silently (no overflow), and only
    // reports overflow when the draw path is free and the sequence is full.
    // The last-slot test is written as ptr+1 >= count so it cannot underflow.
    always_comb begin
        do_rec      = 1'b0;
        do_ovf      = 1'b0;
        do_step     = 1'b0;
        do_wrap     = 1'b0;
        do_finish   = 1'b0;
        load_en     = 1'b0;
        load_slot   = '0;
        load_colour = COLOUR_REC;
        ptr_last    = (({1'b0, ptr} + CNT_ONE) >= count);

        if (clear) begin
            load_en = 1'b0;
        end else if (play_start) begin
            // A restart while the VGA side is stalled keeps the pending
            // request intact; only the slot-0 highlight is skipped.
            if ((count != '0) && !busy) begin
                load_en     = 1'b1;
                load_slot   = '0;
                load_colour = COLOUR_HILITE;
            end
        end else if (rec_strobe && (state == IDLE)) begin
            if (!busy) begin
                if (full) begin
                    do_ovf = 1'b1;
                end else begin
                    do_rec      = 1'b1;
                    load_en     = 1'b1;
                    load_slot   = count[ADDR_W-1:0];
                    load_colour = COLOUR_REC;
                end
            end
        end else if (next_note && (state == PLAY) && !busy) begin
            if (!ptr_last) begin
                do_step     = 1'b1;
                load_en     = 1'b1;
                load_slot   = ptr + ADDR_W'(1);
                load_colour = COLOUR_HILITE;
            end else if (LOOP_EN) begin
                do_wrap     = 1'b1;
                load_en     = 1'b1;
                load_slot   = '0;
                load_colour = COLOUR_HILITE;
            end else begin
                do_finish = 1'b1;
            end
        end

        leave_play = clear || do_finish;
    end

    // Sequence FSM, note counter, play pointer and the two status pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            count     <= '0;
            ptr       <= '0;
            overflow  <= 1'b0;
            play_done <= 1'b0;
        end else begin
            overflow  <= do_ovf;
            play_done <= 1'b0;
            if (clear) begin
                state     <= IDLE;
                count     <= '0;
                ptr       <= '0;
                play_done <= (state == PLAY);
            end else if (play_start) begin
                if (count == '0) begin
                    play_done <= 1'b1;
                end else begin
                    state <= PLAY;
                    ptr   <= '0;
                end
            end else if (do_rec) begin
                count <= count + CNT_ONE;
            end else if (do_step) begin
                ptr <= ptr + ADDR_W'(1);
            end else if (do_wrap) begin
                ptr <= '0;
            end else if (do_finish) begin
                state     <= IDLE;
                ptr       <= '0;
                play_done <= 1'b1;
            end
        end
    end

    // Registered read of the playback slot. The pointer moves on one edge
    // and its code appears on the next; leaving PLAY zeroes the output on
    // the same edge so note_out never shows a stale code in IDLE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            note_out   <= '0;
            note_valid <= 1'b0;
        end else if ((state == PLAY) && !leave_play) begin
            note_out   <= mem[ptr];
            note_valid <= 1'b1;
        end else begin
            note_out   <= '0;
            note_valid <= 1'b0;
        end
    end

    // Single-entry draw holding register. Loads are only decoded while the
    // register is free (empty or being accepted this cycle), so a new
    // request can replace one that is accepted on the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            draw_valid  <= 1'b0;
            draw_x      <= '0;
            draw_y      <= '0;
            draw_colour <= '0;
        end else if (clear) begin
            draw_valid <= 1'b0;
        end else if (load_en) begin
            draw_valid  <= 1'b1;
            draw_x      <= cell_x(load_slot);
            draw_y      <= cell_y(load_slot);
            draw_colour <= load_colour;
        end else if (draw_valid && draw_ready) begin
            draw_valid <= 1'b0;
        end
    end

    // Sequence storage; contents survive reset and clear on purpose, only
    // the count decides which slots are live.
    always_ff @(posedge clk) begin
        if (do_rec) begin
            mem[count[ADDR_W-1:0]] <= {octave_data, note_data};
        end
    end

endmodule

// File: tb/tb_note_seq_datapath.sv
// ----------------------------------------------------------------------------
// tb_note_seq_datapath
//
// Table-driven bench for note_seq_datapath. A list of {stimulus, expected}
// records covers record, playback, clear/restart priority and the stalled
// draw handshake; short hand-written sequences cover filling to overflow,
// reset with a pending draw, and a second instance with an 8-column grid.
// Honours NOTE_SEQ_LOOP_EN for the last-slot expectations.
// ----------------------------------------------------------------------------
module tb_note_seq_datapath;

    typedef struct {
        logic       rec;
        logic       start;
        logic       nxt;
        logic       clr;
        logic       rdy;
        logic [5:0] code;
        logic [4:0] e_count;
        logic       e_full;
        logic       e_ovf;
        logic       e_active;
        logic       e_done;
        logic       e_nvalid;
        logic       e_dvalid;
        logic [5:0] e_note;
        logic [7:0] e_x;
        logic [6:0] e_y;
        logic [2:0] e_col;
        logic       e_busy;
    } vec_t;

    // stimulus bits {rec, start, next, clear, ready}
    localparam logic [4:0] S_REC      = 5'b10001;
    localparam logic [4:0] S_REC_NR   = 5'b10000;
    localparam logic [4:0] S_NONE     = 5'b00001;
    localparam logic [4:0] S_NONE_NR  = 5'b00000;
    localparam logic [4:0] S_START    = 5'b01001;
    localparam logic [4:0] S_NEXT     = 5'b00101;
    localparam logic [4:0] S_CLR      = 5'b00011;
    localparam logic [4:0] S_CLRSTART = 5'b01010;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] note_data;
    logic [1:0] octave_data;
    logic       rec_strobe, play_start, next_note, clear, draw_ready;
    logic [5:0] note_out;
    logic       note_valid, play_active, play_done, full, overflow, busy, draw_valid;
    logic [4:0] count;
    logic [7:0] draw_x;
    logic [6:0] draw_y;
    logic [2:0] draw_colour;

    logic       rec2, ready2;
    logic [3:0] note2;
    logic [5:0] note_out2;
    logic       note_valid2, play_active2, play_done2, full2, overflow2, busy2, draw_valid2;
    logic [5:0] count2;
    logic [7:0] draw_x2;
    logic [6:0] draw_y2;
    logic [2:0] draw_colour2;

    int assertions = 0;
    int failures   = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    note_seq_datapath dut (
        .clk(clk), .reset(reset),
        .note_data(note_data), .octave_data(octave_data),
        .rec_strobe(rec_strobe), .play_start(play_start),
        .next_note(next_note), .clear(clear),
        .note_out(note_out), .note_valid(note_valid),
        .play_active(play_active), .play_done(play_done),
        .count(count), .full(full), .overflow(overflow), .busy(busy),
        .draw_valid(draw_valid), .draw_ready(draw_ready),
        .draw_x(draw_x), .draw_y(draw_y), .draw_colour(draw_colour)
    );

    note_seq_datapath #(
        .DEPTH(32), .ADDR_W(5), .COLS(8), .CELL_W(16), .CELL_H(12), .GAP(4)
    ) dut_wide (
        .clk(clk), .reset(reset),
        .note_data(note2), .octave_data(2'b01),
        .rec_strobe(rec2), .play_start(1'b0),
        .next_note(1'b0), .clear(1'b0),
        .note_out(note_out2), .note_valid(note_valid2),
        .play_active(play_active2), .play_done(play_done2),
        .count(count2), .full(full2), .overflow(overflow2), .busy(busy2),
        .draw_valid(draw_valid2), .draw_ready(ready2),
        .draw_x(draw_x2), .draw_y(draw_y2), .draw_colour(draw_colour2)
    );

    // Builds one record; flags are {full, overflow, active, done, nvalid, dvalid}.
    function automatic vec_t mk(input logic [4:0] stim, input logic [5:0] code,
                                input logic [4:0] cnt, input logic [5:0] flags,
                                input logic [5:0] note, input logic [7:0] x,
                                input logic [6:0] y, input logic [2:0] col);
        vec_t v;
        {v.rec, v.start, v.nxt, v.clr, v.rdy} = stim;
        v.code     = code;
        v.e_count  = cnt;
        {v.e_full, v.e_ovf, v.e_active, v.e_done, v.e_nvalid, v.e_dvalid} = flags;
        v.e_note   = note;
        v.e_x      = x;
        v.e_y      = y;
        v.e_col    = col;
        v.e_busy   = v.e_dvalid && !v.rdy;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int step,
                               input logic [31:0] actual, input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s (step %0d): got 0x%0h, expected 0x%0h",
                     name, step, actual, expected);
        end
    endtask

    // Drives one cycle of inputs before the edge and returns at the
    // following falling edge, where outputs are stable.
    task automatic applyStimulus(input vec_t v);
        rec_strobe  = v.rec;
        play_start  = v.start;
        next_note   = v.nxt;
        clear       = v.clr;
        draw_ready  = v.rdy;
        {octave_data, note_data} = v.code;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkVector(input int step, input vec_t v);
        checkOutput("count",       step, 32'(count),       32'(v.e_count));
        checkOutput("full",        step, 32'(full),        32'(v.e_full));
        checkOutput("overflow",    step, 32'(overflow),    32'(v.e_ovf));
        checkOutput("play_active", step, 32'(play_active), 32'(v.e_active));
        checkOutput("play_done",   step, 32'(play_done),   32'(v.e_done));
        checkOutput("note_valid",  step, 32'(note_valid),  32'(v.e_nvalid));
        checkOutput("note_out",    step, 32'(note_out),    32'(v.e_note));
        checkOutput("draw_valid",  step, 32'(draw_valid),  32'(v.e_dvalid));
        checkOutput("draw_x",      step, 32'(draw_x),      32'(v.e_x));
        checkOutput("draw_y",      step, 32'(draw_y),      32'(v.e_y));
        checkOutput("draw_colour", step, 32'(draw_colour), 32'(v.e_col));
        checkOutput("busy",        step, 32'(busy),        32'(v.e_busy));
    endtask

    initial begin
        vec_t v;

        // Record three notes, play them, then clear/restart corner cases
        // and a stalled draw handshake.
        vecs.push_back(mk(S_REC,   6'h05, 1, 6'b000001, 6'h00,  4, 4, 3'b100));
        vecs.push_back(mk(S_REC,   6'h1A, 2, 6'b000001, 6'h00, 44, 4, 3'b100));
        vecs.push_back(mk(S_REC,   6'h2C, 3, 6'b000001, 6'h00, 84, 4, 3'b100));
        vecs.push_back(mk(S_NONE,  6'h00, 3, 6'b000000, 6'h00, 84, 4, 3'b100));
        vecs.push_back(mk(S_START, 6'h00, 3, 6'b001001, 6'h00,  4, 4, 3'b110));
        vecs.push_back(mk(S_NONE,  6'h00, 3, 6'b001010, 6'h05,  4, 4, 3'b110));
        vecs.push_back(mk(S_NEXT,  6'h00, 3, 6'b001011, 6'h05, 44, 4, 3'b110));
        vecs.push_back(mk(S_NONE,  6'h00, 3, 6'b001010, 6'h1A, 44, 4, 3'b110));
        vecs.push_back(mk(S_NEXT,  6'h00, 3, 6'b001011, 6'h1A, 84, 4, 3'b110));
        vecs.push_back(mk(S_NONE,  6'h00, 3, 6'b001010, 6'h2C, 84, 4, 3'b110));
`ifdef NOTE_SEQ_LOOP_EN
        vecs.push_back(mk(S_NEXT,  6'h00, 3, 6'b001011, 6'h2C,  4, 4, 3'b110));
        vecs.push_back(mk(S_NONE,  6'h00, 3, 6'b001010, 6'h05,  4, 4, 3'b110));
        vecs.push_back(mk(S_START, 6'h00, 3, 6'b001011, 6'h05,  4, 4, 3'b110));
`else
        vecs.push_back(mk(S_NEXT,  6'h00, 3, 6'b000100, 6'h00, 84, 4, 3'b110));
        vecs.push_back(mk(S_NONE,  6'h00, 3, 6'b000000, 6'h00, 84, 4, 3'b110));
        vecs.push_back(mk(S_START, 6'h00, 3, 6'b001001, 6'h00,  4, 4, 3'b110));
`endif
        vecs.push_back(mk(S_CLRSTART, 6'h00, 0, 6'b000100, 6'h00, 4, 4, 3'b110));
        vecs.push_back(mk(S_NONE,  6'h00, 0, 6'b000000, 6'h00,  4, 4, 3'b110));
        vecs.push_back(mk(S_START, 6'h00, 0, 6'b000100, 6'h00,  4, 4, 3'b110));
        vecs.push_back(mk(S_NONE,  6'h00, 0, 6'b000000, 6'h00,  4, 4, 3'b110));
        vecs.push_back(mk(S_REC_NR,  6'h3F, 1, 6'b000001, 6'h00, 4, 4, 3'b100));
        vecs.push_back(mk(S_REC_NR,  6'h01, 1, 6'b000001, 6'h00, 4, 4, 3'b100));
        vecs.push_back(mk(S_NONE_NR, 6'h00, 1, 6'b000001, 6'h00, 4, 4, 3'b100));
        vecs.push_back(mk(S_NONE,  6'h00, 1, 6'b000000, 6'h00,  4, 4, 3'b100));
        vecs.push_back(mk(S_CLR,   6'h00, 0, 6'b000000, 6'h00,  4, 4, 3'b100));

        reset = 1'b0;
        rec_strobe = 1'b0; play_start = 1'b0; next_note = 1'b0; clear = 1'b0;
        draw_ready = 1'b1; note_data = '0; octave_data = '0;
        rec2 = 1'b0; ready2 = 1'b1; note2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkVector(-1, mk(S_NONE, 6'h00, 0, 6'b000000, 6'h00, 0, 0, 3'b000));
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkVector(i, vecs[i]);
        end

        // Fill all 16 slots, then one more record must overflow.
        for (int i = 0; i < 16; i++) begin
            v = mk(S_REC, 6'(i), 5'(i + 1), {(i == 15), 5'b00001}, 6'h00,
                   8'(4 + (i % 4) * 40), 7'(4 + (i / 4) * 16), 3'b100);
            applyStimulus(v);
            checkVector(100 + i, v);
        end
        v = mk(S_REC, 6'h03, 16, 6'b110000, 6'h00, 124, 52, 3'b100);
        applyStimulus(v);
        checkVector(116, v);
        v = mk(S_NONE, 6'h00, 16, 6'b100000, 6'h00, 124, 52, 3'b100);
        applyStimulus(v);
        checkVector(117, v);

        // Reset while a draw is stalled: everything returns to reset values.
        v = mk(S_CLR, 6'h00, 0, 6'b000000, 6'h00, 124, 52, 3'b100);
        applyStimulus(v);
        checkVector(200, v);
        v = mk(S_REC_NR, 6'h11, 1, 6'b000001, 6'h00, 4, 4, 3'b100);
        applyStimulus(v);
        checkVector(201, v);
        reset = 1'b0;
        v = mk(S_NONE_NR, 6'h00, 0, 6'b000000, 6'h00, 0, 0, 3'b000);
        applyStimulus(v);
        checkVector(202, v);
        reset = 1'b1;

        // 8-column grid: slot 9 sits at column 1, row 1.
        for (int i = 0; i < 10; i++) begin
            rec2  = 1'b1;
            note2 = 4'(i);
            @(posedge clk);
            @(negedge clk);
        end
        rec2 = 1'b0;
        checkOutput("wide count",       300, 32'(count2),       32'd10);
        checkOutput("wide draw_valid",  300, 32'(draw_valid2),  32'd1);
        checkOutput("wide draw_x",      300, 32'(draw_x2),      32'd24);
        checkOutput("wide draw_y",      300, 32'(draw_y2),      32'd20);
        checkOutput("wide draw_colour", 300, 32'(draw_colour2), 32'b100);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
